// File: rtl/regfile.sv
// 32-entry architectural register file: two combinational read ports, one clocked write port,
// hardwired-zero register and same-cycle write-through bypass to the read ports.
module regfile #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    logic [WIDTH-1:0] w_regs [32];

    for (genvar gi = 0; gi < 32; gi++) begin : g_reg
        if (gi == ZERO_REG) begin : g_zero
            assign w_regs[gi] = '0;
        end else begin : g_ff
            logic             w_load;
            logic [WIDTH-1:0] r_q;

            // One-hot decode slice: RegWrite acts as the decoder enable.
            assign w_load = RegWrite && (WriteRegister == 5'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= '0;
                end else begin
                    r_q <= w_load ? WriteData : r_q;
                end
            end

            assign w_regs[gi] = r_q;
        end
    end

    // Bypass is independent of reset, so a write presented during reset is still visible.
    always_comb begin
        ReadData1 = w_regs[ReadRegister1];
        if (ReadRegister1 == 5'(ZERO_REG)) begin
            ReadData1 = '0;
        end else if (RegWrite && (WriteRegister == ReadRegister1)) begin
            ReadData1 = WriteData;
        end
    end

    always_comb begin
        ReadData2 = w_regs[ReadRegister2];
        if (ReadRegister2 == 5'(ZERO_REG)) begin
            ReadData2 = '0;
        end else if (RegWrite && (WriteRegister == ReadRegister2)) begin
            ReadData2 = WriteData;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed cases plus random traffic against an array model.
module tb_regfile;

    localparam int unsigned W = 64;

    logic         clk;
    logic         reset;
    logic         RegWrite;
    logic [4:0]   WriteRegister;
    logic [W-1:0] WriteData;
    logic [4:0]   ReadRegister1;
    logic [4:0]   ReadRegister2;
    logic [W-1:0] ReadData1;
    logic [W-1:0] ReadData2;

    logic [W-1:0] mdl [32];
    int unsigned  total;
    int unsigned  bad;

    regfile #(.WIDTH(W), .ZERO_REG(31)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] expect_rd(input logic [4:0] a);
        if (a == 5'd31) return '0;
        if (RegWrite && WriteRegister == a) return WriteData;
        if (reset) return '0;
        return mdl[a];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        #1;
        chk({tag, "_p1"}, ReadData1, expect_rd(ReadRegister1));
        chk({tag, "_p2"}, ReadData2, expect_rd(ReadRegister2));
    endtask

    // Drive at negedge, check combinational reads, then take the edge and update the model.
    task automatic step(input string tag, input logic we, input logic [4:0] wr,
                        input logic [W-1:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        RegWrite = we; WriteRegister = wr; WriteData = wd;
        ReadRegister1 = r1; ReadRegister2 = r2;
        check_ports(tag);
        @(posedge clk);
        if (!reset && we && wr != 5'd31) mdl[wr] = wd;
        else if (reset) foreach (mdl[k]) mdl[k] = '0;
    endtask

    task automatic sweep_reads(input string tag);
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            check_ports(tag);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        foreach (mdl[k]) mdl[k] = '0;
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        #2;
        sweep_reads("reset_init");
        @(negedge clk);
        reset = 1'b0;

        // Fill with nonzero data, then assert reset between edges.
        for (int i = 0; i < 31; i++)
            step("fill", 1'b1, 5'(i), {$urandom, $urandom} | 64'h1, 5'(i), 5'(30 - i));
        @(negedge clk);
        RegWrite = 1'b0;
        #2;
        reset = 1'b1;
        foreach (mdl[k]) mdl[k] = '0;
        sweep_reads("reset_async");

        // Bypass stays live while reset is held.
        RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'hABCD;
        ReadRegister1 = 5'd9; ReadRegister2 = 5'd9;
        #1;
        chk("reset_bypass", ReadData1, 64'hABCD);
        @(posedge clk);
        @(negedge clk);
        RegWrite = 1'b0;
        ReadRegister1 = 5'd9;
        #1;
        chk("reset_write_lost", ReadData1, 64'h0);
        reset = 1'b0;

        // Write/readback with neighbours untouched.
        step("wr_x5", 1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 5'd4, 5'd6);
        step("rd_x5", 1'b0, 5'd5, 64'h0, 5'd5, 5'd4);
        step("rd_x6", 1'b0, 5'd5, 64'h0, 5'd6, 5'd5);
        chk("x5_value", ReadData2, 64'h0123_4567_89AB_CDEF);

        // Same-cycle bypass, then persistence.
        step("byp_x7", 1'b1, 5'd7, 64'hDEAD, 5'd0, 5'd7);
        step("after_x7", 1'b0, 5'd0, 64'h0, 5'd7, 5'd7);
        chk("x7_value", ReadData2, 64'hDEAD);

        // Zero register ignores writes and bypass.
        step("wr_x31", 1'b1, 5'd31, '1, 5'd31, 5'd31);
        chk("x31_during", ReadData1, 64'h0);
        step("rd_x31", 1'b0, 5'd31, '1, 5'd31, 5'd30);
        chk("x31_after", ReadData1, 64'h0);

        // RegWrite low holds state.
        step("x3_init", 1'b1, 5'd3, 64'h1234, 5'd3, 5'd3);
        for (int c = 0; c < 3; c++) step("we_low", 1'b0, 5'd3, 64'h55, 5'd3, 5'd3);
        chk("x3_hold", ReadData1, 64'h1234);

        // Full sweep.
        for (int i = 0; i < 31; i++)
            step("sweep_wr", 1'b1, 5'(i), 64'(i * 32'h1111), 5'(i), 5'(30 - i));
        @(negedge clk);
        RegWrite = 1'b0;
        for (int i = 0; i < 31; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(30 - i);
            #1;
            chk("sweep_p1", ReadData1, 64'(i * 32'h1111));
            chk("sweep_p2", ReadData2, 64'((30 - i) * 32'h1111));
        end
        ReadRegister1 = 5'd31;
        #1;
        chk("sweep_x31", ReadData1, 64'h0);

        // Random traffic.
        for (int n = 0; n < 400; n++)
            step("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 {$urandom, $urandom}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        @(negedge clk);
        RegWrite = 1'b0;
        sweep_reads("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
